data_pack: RTL and testbench

Packs a stream of 7-bit symbols with packet framing (sop/eop) into 32-bit words with matching framing. It is the transmit-side counterpart of the 32→7 unpacker: a packet unpacked to symbols and fed through this block must reproduce the original words bit-for-bit. Both sides use valid/ready handshakes, so the block sits between a symbol source and a word-wide sink that can apply back pressure.

---
 rtl/data_pack.sv | 135 +++++++++++++
 tb/tb_data_pack.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_pack.sv
// Packs a framed stream of 7-bit symbols LSB-first into 32-bit words with sop/eop/fill framing.
// Valid/ready on both sides; one registered output stage.
module data_pack #(
  parameter int unsigned IN_WIDTH  = 7,
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [IN_WIDTH-1:0]  data_in,
  input  logic                 sop_in,
  input  logic                 eop_in,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 sop_out,
  output logic                 eop_out,
  output logic [5:0]           fill_out
);

  typedef enum logic [1:0] {StIdle, StPack, StFlush} state_e;

  state_e      state_q, state_d;
  logic [37:0] acc_q, acc_d;
  logic [5:0]  fill_q, fill_d;
  logic        first_q, first_d;

  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic [5:0]  fillo_q, fillo_d;

  logic        slot_free;
  logic        accept;
  logic [37:0] base_acc;
  logic [5:0]  base_fill;
  logic        base_first;
  logic [37:0] merged;
  logic [5:0]  total;

  assign slot_free = ~valid_q | ready_in;
  assign ready_out = rst & (state_q != StFlush) & slot_free;
  assign accept    = valid_in & ready_out;

  // A sop always restarts accumulation, discarding any partial packet.
  assign base_acc   = sop_in ? '0 : acc_q;
  assign base_fill  = sop_in ? 6'd0 : fill_q;
  assign base_first = sop_in ? 1'b1 : first_q;
  assign merged     = base_acc | ({31'b0, data_in} << base_fill);
  assign total      = base_fill + 6'd7;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    first_d = first_q;
    valid_d = valid_q & ~ready_in;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    fillo_d = fillo_q;

    if (state_q == StFlush) begin
      if (slot_free) begin
        valid_d = 1'b1;
        data_d  = acc_q[31:0];
        sop_d   = 1'b0;
        eop_d   = 1'b1;
        fillo_d = fill_q;
        acc_d   = '0;
        fill_d  = 6'd0;
        first_d = 1'b0;
        state_d = StIdle;
      end
    end else if (accept && (state_q == StPack || sop_in)) begin
      if (!eop_in && total < 6'd32) begin
        acc_d   = merged;
        fill_d  = total;
        first_d = base_first;
        state_d = StPack;
      end else begin
        valid_d = 1'b1;
        data_d  = merged[31:0];
        sop_d   = base_first;
        first_d = 1'b0;
        if (eop_in && total <= 6'd32) begin
          eop_d   = 1'b1;
          fillo_d = total;
          acc_d   = '0;
          fill_d  = 6'd0;
          state_d = StIdle;
        end else begin
          eop_d   = 1'b0;
          fillo_d = 6'd32;
          acc_d   = merged >> 32;
          fill_d  = total - 6'd32;
          state_d = eop_in ? StFlush : StPack;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      fill_q  <= 6'd0;
      first_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      fillo_q <= 6'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      first_q <= first_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      fillo_q <= fillo_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign sop_out   = sop_q;
  assign eop_out   = eop_q;
  assign fill_out  = fillo_q;

endmodule

// File: tb/tb_data_pack.sv
// Directed bench for data_pack: packet-level bit-stream model plus literal word expectations.
module tb_data_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [6:0]  data_in = '0;
  logic        sop_in = 1'b0;
  logic        eop_in = 1'b0;
  logic        valid_out;
  logic        ready_in = 1'b1;
  logic [31:0] data_out;
  logic        sop_out;
  logic        eop_out;
  logic [5:0]  fill_out;

  data_pack dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_in   (data_in),
    .sop_in    (sop_in),
    .eop_in    (eop_in),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .sop_out   (sop_out),
    .eop_out   (eop_out),
    .fill_out  (fill_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        s;
    logic        e;
    logic [5:0]  f;
  } word_t;

  word_t      exp_q[$];
  word_t      got_q[$];
  logic [6:0] pkt[$];
  int         checks = 0;
  int         failures = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endfunction

  // Model: concatenate packet symbols into one bit stream, then cut it into 32-bit words.
  function automatic void model_packet();
    logic [511:0] bits = '0;
    int nb = pkt.size() * 7;
    int nw = (nb + 31) / 32;
    word_t x;
    for (int i = 0; i < pkt.size(); i++) bits |= 512'(pkt[i]) << (7 * i);
    for (int w = 0; w < nw; w++) begin
      x.d = bits[32*w +: 32];
      x.s = (w == 0);
      x.e = (w == nw - 1);
      x.f = (nb - 32 * w >= 32) ? 6'd32 : 6'(nb - 32 * w);
      exp_q.push_back(x);
    end
  endfunction

  task automatic send(input logic [6:0] d, input logic s, input logic e);
    logic took;
    int n = 0;
    valid_in = 1'b1;
    data_in  = d;
    sop_in   = s;
    eop_in   = e;
    do begin
      @(negedge clk);
      took = ready_out;
      @(posedge clk);
      #1;
      n++;
    end while (!took && n < 200);
    if (!took) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got ready_out=0 expected ready_out=1 within 200 cycles");
    end
    valid_in = 1'b0;
    sop_in   = 1'b0;
    eop_in   = 1'b0;
  endtask

  task automatic send_pkt();
    model_packet();
    for (int i = 0; i < pkt.size(); i++) send(pkt[i], i == 0, i == pkt.size() - 1);
    pkt.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare process: every transferred word against the model, plus hold/back-pressure rules.
  word_t prev_w;
  logic  prev_hold = 1'b0;
  always @(negedge clk) begin
    word_t cur;
    cur = {data_out, sop_out, eop_out, fill_out};
    if (rst) begin
      if (prev_hold && valid_out) chk("hold_stable", 64'(cur), 64'(prev_w));
      if (valid_out && !ready_in) chk("bp_ready_out", 64'(ready_out), 64'd0);
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got 0x%0h expected no word", cur);
        end else begin
          chk("word", 64'(cur), 64'(exp_q.pop_front()));
        end
        got_q.push_back(cur);
      end
      prev_hold = valid_out && !ready_in;
      prev_w    = cur;
    end else begin
      prev_hold = 1'b0;
    end
  end

  int base;

  initial begin
    #2;
    chk("reset_valid_out", 64'(valid_out), 64'd0);
    chk("reset_ready_out", 64'(ready_out), 64'd0);
    chk("reset_data_out", 64'(data_out), 64'd0);
    chk("reset_flags", 64'({sop_out, eop_out, fill_out}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(1);
    chk("ready_after_reset", 64'(ready_out), 64'd1);

    // Straddling packet with a FLUSH residual
    base = got_q.size();
    pkt = '{7'h01, 7'h02, 7'h03, 7'h04, 7'h7F};
    send_pkt();
    @(negedge clk);
    chk("flush_ready_low", 64'(ready_out), 64'd0);
    idle(3);
    chk("t1_count", 64'(got_q.size() - base), 64'd2);
    if (got_q.size() >= base + 2) begin
      chk("t1_w0", 64'(got_q[base]), 64'({32'hF080C101, 1'b1, 1'b0, 6'd32}));
      chk("t1_w1", 64'(got_q[base+1]), 64'({32'h00000007, 1'b0, 1'b1, 6'd3}));
    end

    // One-symbol packet
    base = got_q.size();
    model_packet_one(7'h55);
    idle(2);
    if (got_q.size() > base)
      chk("t2_w0", 64'(got_q[base]), 64'({32'h00000055, 1'b1, 1'b1, 6'd7}));
    else chk("t2_count", 64'(got_q.size() - base), 64'd1);

    // 32 x 0x7F: seven full words, no flush
    base = got_q.size();
    for (int i = 0; i < 32; i++) pkt.push_back(7'h7F);
    send_pkt();
    idle(3);
    chk("t3_count", 64'(got_q.size() - base), 64'd7);
    if (got_q.size() >= base + 7) begin
      chk("t3_w0", 64'(got_q[base]), 64'({32'hFFFFFFFF, 1'b1, 1'b0, 6'd32}));
      chk("t3_w3", 64'(got_q[base+3]), 64'({32'hFFFFFFFF, 1'b0, 1'b0, 6'd32}));
      chk("t3_w6", 64'(got_q[base+6]), 64'({32'hFFFFFFFF, 1'b0, 1'b1, 6'd32}));
    end

    // Back pressure on a produced word
    base = got_q.size();
    ready_in = 1'b0;
    model_packet_one(7'h2A);
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid_held", 64'(valid_out), 64'd1);
      chk("bp_data_held", 64'(data_out), 64'h2A);
    end
    @(posedge clk);
    #1 ready_in = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_released_ready", 64'(ready_out), 64'd1);
    chk("bp_released_valid", 64'(valid_out), 64'd0);
    chk("bp_count", 64'(got_q.size() - base), 64'd1);

    // Junk symbols in IDLE are dropped; next packet packs from bit 0
    send(7'h11, 1'b0, 1'b0);
    send(7'h22, 1'b0, 1'b0);
    @(negedge clk);
    chk("junk_no_valid", 64'(valid_out), 64'd0);
    base = got_q.size();
    pkt = '{7'h05, 7'h06};
    send_pkt();
    idle(2);
    if (got_q.size() > base)
      chk("t5_w0", 64'(got_q[base]), 64'({32'h00000305, 1'b1, 1'b1, 6'd14}));
    else chk("t5_count", 64'(got_q.size() - base), 64'd1);

    // Asynchronous reset mid-packet
    send(7'h01, 1'b1, 1'b0);
    send(7'h02, 1'b0, 1'b0);
    send(7'h03, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("rst_async_valid", 64'(valid_out), 64'd0);
    chk("rst_async_ready", 64'(ready_out), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(1);
    chk("rst_no_word", 64'(valid_out), 64'd0);
    base = got_q.size();
    pkt = '{7'h01, 7'h02};
    send_pkt();
    idle(2);
    if (got_q.size() > base)
      chk("t6_w0", 64'(got_q[base]), 64'({32'h00000101, 1'b1, 1'b1, 6'd14}));
    else chk("t6_count", 64'(got_q.size() - base), 64'd1);

    idle(3);
    chk("model_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic model_packet_one(input logic [6:0] d);
    pkt = '{d};
    model_packet();
    pkt.delete();
    send(d, 1'b1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
    $fatal(1);
  end

endmodule
